// File: rtl/sprite_layer_addr_engine.sv
// Multi-layer sprite address engine.
// Each layer owns a runtime window, a ROM base/stride and a frame sequencer.
// Pipeline: stage 1 does the per-layer hit test and offsets, and stage 2
// priority-selects one layer and forms the ROM word address.

module sprite_layer_unit #(
    parameter int ADDR_W = 25
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start_i,
    input  logic              cfg_we_i,
    input  logic [2:0]        cfg_field_i,
    input  logic [ADDR_W-1:0] cfg_data_i,
    input  logic [9:0]        pix_x_i,
    input  logic [9:0]        pix_y_i,
    output logic              hit_o,
    output logic [19:0]       off_o,
    output logic [ADDR_W-1:0] fofs_o,
    output logic [ADDR_W-1:0] base_o,
    output logic              done_o
);
    logic [9:0]        x_q, y_q, w_q, h_q;
    logic [ADDR_W-1:0] base_q, stride_q;
    logic [14:0]       ctrl_q;
    logic [3:0]        frame_q, frame_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic              done_q, done_d;

    logic              s1_hit_q;
    logic [19:0]       s1_off_q;
    logic [ADDR_W-1:0] s1_fofs_q, s1_base_q;

    logic              en;
    logic [1:0]        mode;
    logic [3:0]        last;
    logic [7:0]        period;
    logic              ctrl_wr;

    assign en      = ctrl_q[0];
    assign mode    = ctrl_q[2:1];
    assign last    = ctrl_q[6:3];
    assign period  = ctrl_q[14:7];
    assign ctrl_wr = cfg_we_i && (cfg_field_i == 3'd6);

    // Configuration register file; field 7 is a hole and is ignored.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            base_q   <= '0;
            stride_q <= '0;
            ctrl_q   <= '0;
        end else if (cfg_we_i) begin
            case (cfg_field_i)
                3'd0:    x_q      <= cfg_data_i[9:0];
                3'd1:    y_q      <= cfg_data_i[9:0];
                3'd2:    w_q      <= cfg_data_i[9:0];
                3'd3:    h_q      <= cfg_data_i[9:0];
                3'd4:    base_q   <= cfg_data_i;
                3'd5:    stride_q <= cfg_data_i;
                3'd6:    ctrl_q   <= cfg_data_i[14:0];
                default: ;
            endcase
        end
    end

    // Frame sequencer; a CTRL write restarts the animation and beats a coincident vsync.
    always_comb begin
        frame_d = frame_q;
        pcnt_d  = pcnt_q;
        done_d  = done_q;
        if (ctrl_wr) begin
            frame_d = '0;
            pcnt_d  = '0;
            done_d  = 1'b0;
        end else if (frame_start_i && en) begin
            if (period == 8'd0 || pcnt_q == period - 8'd1) begin
                pcnt_d = '0;
                case (mode)
                    2'd1: begin
                        if (frame_q >= last) begin
                            done_d = 1'b1;
                        end else begin
                            frame_d = frame_q + 4'd1;
                            if (frame_q + 4'd1 == last) done_d = 1'b1;
                        end
                    end
                    2'd2:    frame_d = (frame_q >= last) ? 4'd0 : frame_q + 4'd1;
                    default: frame_d = '0;
                endcase
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
        end
    end

    // Sequencer state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_q <= '0;
            pcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
        end
    end

    // Window ends are 11 bits wide so windows can hang past the screen edge.
    logic [10:0] x_end, y_end;
    logic [9:0]  dx, dy;
    logic        hit;
    assign x_end = {1'b0, x_q} + {1'b0, w_q};
    assign y_end = {1'b0, y_q} + {1'b0, h_q};
    assign dx    = pix_x_i - x_q;
    assign dy    = pix_y_i - y_q;
    assign hit   = en && ({1'b0, pix_x_i} >= {1'b0, x_q}) && ({1'b0, pix_x_i} < x_end)
                      && ({1'b0, pix_y_i} >= {1'b0, y_q}) && ({1'b0, pix_y_i} < y_end);

    // Stage 1: snapshot hit, offset, frame offset and base, so later config changes miss this pixel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_hit_q  <= 1'b0;
            s1_off_q  <= '0;
            s1_fofs_q <= '0;
            s1_base_q <= '0;
        end else begin
            s1_hit_q  <= hit;
            s1_off_q  <= 20'(dy) * 20'(w_q) + 20'(dx);
            s1_fofs_q <= ADDR_W'(frame_q) * stride_q;
            s1_base_q <= base_q;
        end
    end

    assign hit_o  = s1_hit_q;
    assign off_o  = s1_off_q;
    assign fofs_o = s1_fofs_q;
    assign base_o = s1_base_q;
    assign done_o = done_q;
endmodule

module sprite_layer_addr_engine #(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 25,
    parameter int LIDX_W     = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_start,
    input  logic                  pix_valid,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic                  cfg_we,
    input  logic [LIDX_W-1:0]     cfg_layer,
    input  logic [2:0]            cfg_field,
    input  logic [ADDR_W-1:0]     cfg_data,
    output logic                  out_valid,
    output logic                  hit_out,
    output logic [LIDX_W-1:0]     layer_out,
    output logic [ADDR_W-1:0]     addr_out,
    output logic [NUM_LAYERS-1:0] anim_done
);
    logic [NUM_LAYERS-1:0]             l_hit;
    logic [NUM_LAYERS-1:0][19:0]       l_off;
    logic [NUM_LAYERS-1:0][ADDR_W-1:0] l_fofs;
    logic [NUM_LAYERS-1:0][ADDR_W-1:0] l_base;
    logic [1:0]                        vld_pipe;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        sprite_layer_unit #(.ADDR_W(ADDR_W)) u_layer (
            .Clk           (Clk),
            .Reset         (Reset),
            .frame_start_i (frame_start),
            .cfg_we_i      (cfg_we && (cfg_layer == LIDX_W'(g))),
            .cfg_field_i   (cfg_field),
            .cfg_data_i    (cfg_data),
            .pix_x_i       (DrawX),
            .pix_y_i       (DrawY),
            .hit_o         (l_hit[g]),
            .off_o         (l_off[g]),
            .fofs_o        (l_fofs[g]),
            .base_o        (l_base[g]),
            .done_o        (anim_done[g])
        );
    end

    // Priority pick: scan from the top so the lowest-index hit is the one left standing.
    logic              sel_hit_d;
    logic [LIDX_W-1:0] sel_idx_d;
    logic [ADDR_W-1:0] sel_addr_d;
    always_comb begin
        sel_hit_d  = 1'b0;
        sel_idx_d  = '0;
        sel_addr_d = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (l_hit[i] && vld_pipe[0]) begin
                sel_hit_d  = 1'b1;
                sel_idx_d  = LIDX_W'(i);
                sel_addr_d = l_base[i] + l_fofs[i] + ADDR_W'(l_off[i]);
            end
        end
    end

    // Valid shift register and stage-2 output registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_pipe  <= '0;
            hit_out   <= 1'b0;
            layer_out <= '0;
            addr_out  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[0], pix_valid};
            hit_out   <= sel_hit_d;
            layer_out <= sel_idx_d;
            addr_out  <= sel_addr_d;
        end
    end

    assign out_valid = vld_pipe[1];
endmodule
